// File: rtl/prio_event_encoder.sv
// prio_event_encoder: sticky request capture with a registered valid/ready
// encoded-index output. Each accepted index clears its pending bit.
// Optional build macro: PRIO_ROUND_ROBIN_EN selects rotating priority
// (pointer search) instead of fixed lowest-index-first priority.
module prio_event_encoder #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [N-1:0] req,
  input  logic         enc_ready,
  output logic         enc_valid,
  output logic [W-1:0] enc_idx,
  output logic         busy,
  output logic         ovf
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           ovf_q, ovf_d;

  logic           fire;
  logic [N-1:0]   served;
  logic [N-1:0]   avail;
  logic           any_avail;
  logic [W-1:0]   sel_idx;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  // Handshake decode: the presented index is consumed this cycle.
  always_comb begin
    fire   = 1'b0;
    served = '0;
    fire   = (state_q == ST_HOLD) && enc_ready;
    for (int i = 0; i < N; i++) begin
      if (fire && (idx_q == W'(i))) served[i] = 1'b1;
    end
  end

  assign avail     = pending_q & ~served;
  assign any_avail = |avail;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [W-1:0]   ptr_q, ptr_d;
  logic [2*N-1:0] avail_dbl;
  logic [N-1:0]   avail_rot;
  logic [W-1:0]   rot_off;
  logic [W:0]     rot_sum;

  // Rotating search: rotate avail so the pointer bit lands at position 0,
  // find the lowest set bit, then map the offset back modulo N.
  always_comb begin
    avail_dbl = {avail, avail};
    avail_rot = N'(avail_dbl >> ptr_q);
    rot_off   = lowest_set(avail_rot);
    rot_sum   = {1'b0, ptr_q} + {1'b0, rot_off};
    if (rot_sum >= (W+1)'(N)) rot_sum = rot_sum - (W+1)'(N);
    sel_idx   = rot_sum[W-1:0];
  end

  // Pointer moves just past the index that was accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (fire) begin
      ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    sel_idx = lowest_set(avail);
  end
`endif

  // Pending/overflow next state; a request on the bit being served re-pends.
  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (clr) begin
      pending_d = '0;
      ovf_d     = 1'b0;
    end else begin
      pending_d = (pending_q & ~served) | req;
      ovf_d     = ovf_q | (|(req & pending_q & ~served));
    end
  end

  // Output FSM next state: load a new index when idle or when accepted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_avail) begin
            state_d = ST_HOLD;
            idx_d   = sel_idx;
          end
        end
        ST_HOLD: begin
          if (enc_ready) begin
            if (any_avail) begin
              state_d = ST_HOLD;
              idx_d   = sel_idx;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, index, pending and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign enc_valid = (state_q == ST_HOLD);
  assign enc_idx   = idx_q;
  assign ovf       = ovf_q;
  assign busy      = |pending_q;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed testbench for prio_event_encoder (N=8 main instance, N=5 instance
// for the non-power-of-2 index range). Works with or without
// PRIO_ROUND_ROBIN_EN; the chosen sequences give the same order in both.
module tb_prio_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] req;
  logic       enc_ready;
  logic       enc_valid;
  logic [2:0] enc_idx;
  logic       busy;
  logic       ovf;

  logic       clr5;
  logic [4:0] req5;
  logic       ready5;
  logic       valid5;
  logic [2:0] idx5;
  logic       busy5;
  logic       ovf5;

  int vectors    = 0;
  int miscompares = 0;

  prio_event_encoder #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .enc_ready(enc_ready),
    .enc_valid(enc_valid), .enc_idx(enc_idx), .busy(busy), .ovf(ovf)
  );

  prio_event_encoder #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr5), .req(req5), .enc_ready(ready5),
    .enc_valid(valid5), .enc_idx(idx5), .busy(busy5), .ovf(ovf5)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = 8'h08; enc_ready = 1'b0;
    tick();                       // pending bit 3
    tick();                       // HOLD idx 3, req again -> ovf
    tick();
    req = 8'h00;
    vectors++; if (enc_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid: got %b want 1", enc_valid); end
    vectors++; if (enc_idx !== 3'd3) begin miscompares++; $display("FAIL pre_reset_idx: got %0d want 3", enc_idx); end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL pre_reset_ovf: got %b want 1", ovf); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (enc_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", enc_valid); end
    vectors++; if (enc_idx !== 3'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", enc_idx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 8'h10; enc_ready = 1'b1;
    tick();
    req = 8'h00;
    vectors++; if (enc_valid !== 1'b0) begin miscompares++; $display("FAIL single_lat1_valid: got %b want 0", enc_valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    vectors++; if (enc_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", enc_valid); end
    vectors++; if (enc_idx !== 3'd4) begin miscompares++; $display("FAIL single_idx: got %0d want 4", enc_idx); end
    tick();
    vectors++; if (enc_valid !== 1'b0) begin miscompares++; $display("FAIL single_oneshot: got %b want 0", enc_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_multi();
    logic [2:0] exp_seq [3];
`ifdef PRIO_ROUND_ROBIN_EN
    exp_seq = '{3'd7, 3'd0, 3'd3};  // pointer sits at 5 after index 4 fired
`else
    exp_seq = '{3'd0, 3'd3, 3'd7};
`endif
    req = 8'h89; enc_ready = 1'b1;
    tick();
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (enc_valid !== 1'b1 || enc_idx !== exp_seq[i]) begin
        miscompares++; $display("FAIL multi_seq%0d: got v=%b idx=%0d want v=1 idx=%0d", i, enc_valid, enc_idx, exp_seq[i]);
      end
    end
    tick();
    vectors++; if (enc_valid !== 1'b0) begin miscompares++; $display("FAIL multi_drain: got %b want 0", enc_valid); end
  endtask

  task automatic test_backpressure();
    enc_ready = 1'b0; req = 8'h02;
    tick();
    req = 8'h01;
    tick();
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (enc_valid !== 1'b1 || enc_idx !== 3'd1) begin
        miscompares++; $display("FAIL bp_hold%0d: got v=%b idx=%0d want v=1 idx=1", i, enc_valid, enc_idx);
      end
      tick();
    end
    enc_ready = 1'b1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %b want 1", busy); end
    tick();
    vectors++; if (enc_valid !== 1'b1 || enc_idx !== 3'd0) begin
      miscompares++; $display("FAIL bp_second: got v=%b idx=%0d want v=1 idx=0", enc_valid, enc_idx);
    end
    tick();
    vectors++; if (enc_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", enc_valid); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL bp_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_repend_fire();
    enc_ready = 1'b1; req = 8'h04;
    tick();
    req = 8'h00;
    tick();                       // presenting idx 2; next edge fires it
    vectors++; if (enc_valid !== 1'b1 || enc_idx !== 3'd2) begin
      miscompares++; $display("FAIL repend_first: got v=%b idx=%0d want v=1 idx=2", enc_valid, enc_idx);
    end
    req = 8'h04;
    tick();
    req = 8'h00;
    vectors++; if (enc_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL repend_gap: got v=%b busy=%b want v=0 busy=1", enc_valid, busy);
    end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL repend_ovf: got %b want 0", ovf); end
    tick();
    vectors++; if (enc_valid !== 1'b1 || enc_idx !== 3'd2) begin
      miscompares++; $display("FAIL repend_again: got v=%b idx=%0d want v=1 idx=2", enc_valid, enc_idx);
    end
    tick();
    vectors++; if (enc_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL repend_drain: got v=%b busy=%b want 0 0", enc_valid, busy);
    end
  endtask

  task automatic test_overflow();
    enc_ready = 1'b0; req = 8'h04;
    tick();
    tick();                       // second req on pending bit 2
    req = 8'h00;
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", ovf); end
    vectors++; if (enc_valid !== 1'b1 || enc_idx !== 3'd2) begin
      miscompares++; $display("FAIL ovf_idx: got v=%b idx=%0d want v=1 idx=2", enc_valid, enc_idx);
    end
    enc_ready = 1'b1;
    tick();
    vectors++; if (enc_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_single_emit: got %b want 0", enc_valid); end
    tick();
    vectors++; if (enc_valid !== 1'b0 || ovf !== 1'b1) begin
      miscompares++; $display("FAIL ovf_sticky: got v=%b ovf=%b want v=0 ovf=1", enc_valid, ovf);
    end
  endtask

  task automatic test_clr();
    enc_ready = 1'b0; req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    vectors++; if (enc_valid !== 1'b1) begin miscompares++; $display("FAIL clr_pre_valid: got %b want 1", enc_valid); end
    clr = 1'b1; req = 8'hFF; enc_ready = 1'b1;
    tick();
    clr = 1'b0; req = 8'h00;
    vectors++; if (enc_valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL clr_state: got v=%b busy=%b ovf=%b want 0 0 0", enc_valid, busy, ovf);
    end
    tick();
    vectors++; if (enc_valid !== 1'b0) begin miscompares++; $display("FAIL clr_stays_idle: got %b want 0", enc_valid); end
  endtask

  task automatic test_n5();
    req5 = 5'h10;
    tick();
    req5 = 5'h00;
    tick();
    vectors++; if (valid5 !== 1'b1 || idx5 !== 3'd4) begin
      miscompares++; $display("FAIL n5_top: got v=%b idx=%0d want v=1 idx=4", valid5, idx5);
    end
    tick();
    vectors++; if (valid5 !== 1'b0) begin miscompares++; $display("FAIL n5_drain: got %b want 0", valid5); end
    req5 = 5'h1F;
    tick();
    req5 = 5'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (valid5 !== 1'b1 || idx5 !== 3'(i)) begin
        miscompares++; $display("FAIL n5_seq%0d: got v=%b idx=%0d want v=1 idx=%0d", i, valid5, idx5, i);
      end
    end
    tick();
    vectors++; if (valid5 !== 1'b0 || ovf5 !== 1'b0) begin
      miscompares++; $display("FAIL n5_end: got v=%b ovf=%b want 0 0", valid5, ovf5);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; req = 8'h00; enc_ready = 1'b0;
    clr5 = 1'b0; req5 = 5'h00; ready5 = 1'b1;
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_repend_fire();
    test_overflow();
    test_clr();
    test_n5();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
